// File: rtl/mmc1_config_sequencer.sv
// Serial-port programmer for MMC1-class mappers: turns one parallel register write
// into an optional reset write plus five LSB-first bus writes, and tracks shadow copies.
module mmc1_config_sequencer #(
  parameter int unsigned M2_HALF = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       req_valid_i,
  output logic       req_ready_o,
  input  logic [1:0] req_sel_i,
  input  logic [4:0] req_data_i,
  input  logic       req_reset_i,
  output logic       cpu_m2_o,
  output logic       ncpu_romsel_o,
  output logic       ncpu_rw_o,
  output logic       cpu_a14_o,
  output logic       cpu_a13_o,
  output logic       cpu_d0_o,
  output logic       cpu_d7_o,
  output logic       busy_o,
  output logic       done_o,
  output logic [4:0] sh_control_o,
  output logic [4:0] sh_chr0_o,
  output logic [4:0] sh_chr1_o,
  output logic [4:0] sh_prg_o,
  output logic       sh_valid_o
);

  localparam logic [7:0] HALF_LAST = 8'(M2_HALF - 1);
  localparam logic [4:0] CTRL_RESET_BITS = 5'b01100;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_STROBE = 2'd2,
    S_GAP    = 2'd3
  } state_e;

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       gap_hi_q, gap_hi_d;
  logic [2:0] slot_q, slot_d;
  logic [1:0] sel_q, sel_d;
  logic [4:0] data_q, data_d;
  logic [4:0] sh_control_q, sh_control_d;
  logic [4:0] sh_chr0_q, sh_chr0_d;
  logic [4:0] sh_chr1_q, sh_chr1_d;
  logic [4:0] sh_prg_q, sh_prg_d;
  logic       sh_valid_q, sh_valid_d;
  logic       done_q, done_d;

  logic       m2_q, m2_d;
  logic       romsel_n_q, romsel_n_d;
  logic       rw_n_q, rw_n_d;
  logic [1:0] addr_q, addr_d;
  logic       d0_q, d0_d;
  logic       d7_q, d7_d;
  logic       ready_q, ready_d;
  logic       busy_q, busy_d;
  logic       write_ph_s;

  // Slot n (1..5) carries data bit n-1; slot 0 is the reset write and carries no data.
  function automatic logic data_bit(input logic [4:0] d, input logic [2:0] s);
    logic b;
    case (s)
      3'd1:    b = d[0];
      3'd2:    b = d[1];
      3'd3:    b = d[2];
      3'd4:    b = d[3];
      3'd5:    b = d[4];
      default: b = 1'b0;
    endcase
    return b;
  endfunction

  // Sequencing state, request latch and shadow updates.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    gap_hi_d     = gap_hi_q;
    slot_d       = slot_q;
    sel_d        = sel_q;
    data_d       = data_q;
    sh_control_d = sh_control_q;
    sh_chr0_d    = sh_chr0_q;
    sh_chr1_d    = sh_chr1_q;
    sh_prg_d     = sh_prg_q;
    sh_valid_d   = sh_valid_q;
    done_d       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_valid_i) begin
          sel_d    = req_sel_i;
          data_d   = req_data_i;
          slot_d   = req_reset_i ? 3'd0 : 3'd1;
          cnt_d    = 8'd0;
          gap_hi_d = 1'b0;
          state_d  = S_SETUP;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SETUP, S_STROBE, S_GAP: begin
        if (cnt_q != HALF_LAST) begin
          cnt_d = cnt_q + 8'd1;
        end else begin
          cnt_d = 8'd0;
          if (state_q == S_SETUP) begin
            state_d = S_STROBE;
          end else if (state_q == S_STROBE) begin
            // M2 falls here: this is the edge the mapper latches the bit on.
            state_d  = S_GAP;
            gap_hi_d = 1'b0;
            if (slot_q == 3'd0) begin
              sh_control_d = sh_control_q | CTRL_RESET_BITS;
              sh_valid_d   = 1'b1;
            end else if (slot_q == 3'd5) begin
              case (sel_q)
                2'b00:   sh_control_d = data_q;
                2'b01:   sh_chr0_d    = data_q;
                2'b10:   sh_chr1_d    = data_q;
                default: sh_prg_d     = data_q;
              endcase
            end else begin
              sh_valid_d = sh_valid_q;
            end
          end else if (!gap_hi_q) begin
            gap_hi_d = 1'b1;
          end else if (slot_q == 3'd5) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else begin
            slot_d  = slot_q + 3'd1;
            state_d = S_SETUP;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Bus pin values for the coming cycle, derived from the next state so they register cleanly.
  always_comb begin
    write_ph_s = (state_d == S_SETUP) || (state_d == S_STROBE);
    m2_d       = (state_d == S_STROBE) || ((state_d == S_GAP) && gap_hi_d);
    romsel_n_d = (state_d != S_STROBE);
    rw_n_d     = !write_ph_s;
    addr_d     = (state_d == S_IDLE) ? 2'b00 : sel_d;
    d7_d       = write_ph_s && (slot_d == 3'd0);
    d0_d       = write_ph_s && data_bit(data_d, slot_d);
    ready_d    = (state_d == S_IDLE);
    busy_d     = (state_d != S_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= S_IDLE;
      cnt_q        <= 8'd0;
      gap_hi_q     <= 1'b0;
      slot_q       <= 3'd0;
      sel_q        <= 2'b00;
      data_q       <= 5'd0;
      sh_control_q <= CTRL_RESET_BITS;
      sh_chr0_q    <= 5'd0;
      sh_chr1_q    <= 5'd0;
      sh_prg_q     <= 5'd0;
      sh_valid_q   <= 1'b0;
      done_q       <= 1'b0;
      m2_q         <= 1'b0;
      romsel_n_q   <= 1'b1;
      rw_n_q       <= 1'b1;
      addr_q       <= 2'b00;
      d0_q         <= 1'b0;
      d7_q         <= 1'b0;
      ready_q      <= 1'b1;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      gap_hi_q     <= gap_hi_d;
      slot_q       <= slot_d;
      sel_q        <= sel_d;
      data_q       <= data_d;
      sh_control_q <= sh_control_d;
      sh_chr0_q    <= sh_chr0_d;
      sh_chr1_q    <= sh_chr1_d;
      sh_prg_q     <= sh_prg_d;
      sh_valid_q   <= sh_valid_d;
      done_q       <= done_d;
      m2_q         <= m2_d;
      romsel_n_q   <= romsel_n_d;
      rw_n_q       <= rw_n_d;
      addr_q       <= addr_d;
      d0_q         <= d0_d;
      d7_q         <= d7_d;
      ready_q      <= ready_d;
      busy_q       <= busy_d;
    end
  end

  assign req_ready_o   = ready_q;
  assign cpu_m2_o      = m2_q;
  assign ncpu_romsel_o = romsel_n_q;
  assign ncpu_rw_o     = rw_n_q;
  assign cpu_a14_o     = addr_q[1];
  assign cpu_a13_o     = addr_q[0];
  assign cpu_d0_o      = d0_q;
  assign cpu_d7_o      = d7_q;
  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign sh_control_o  = sh_control_q;
  assign sh_chr0_o     = sh_chr0_q;
  assign sh_chr1_o     = sh_chr1_q;
  assign sh_prg_o      = sh_prg_q;
  assign sh_valid_o    = sh_valid_q;

endmodule

// File: tb/tb_mmc1_config_sequencer.sv
// Table-driven bench for mmc1_config_sequencer: one instance with M2_HALF=4, one with M2_HALF=1.
module tb_mmc1_config_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_valid = 1'b0;
  logic       use1 = 1'b0;
  logic [1:0] req_sel = 2'b00;
  logic [4:0] req_data = 5'd0;
  logic       req_reset = 1'b0;
  wire  [30:0] bus4, bus1;
  wire  ready4, ready1;

  int n_pass = 0;
  int n_total = 0;
  int m2_rises = 0;
  int last_strobe = -1;
  logic prev_m2 = 1'b0;
  logic prev_romsel = 1'b1;

  always #5 clk = ~clk;

  mmc1_config_sequencer #(.M2_HALF(4)) dut4 (
    .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid & ~use1), .req_ready_o(ready4),
    .req_sel_i(req_sel), .req_data_i(req_data), .req_reset_i(req_reset),
    .cpu_m2_o(bus4[30]), .ncpu_romsel_o(bus4[29]), .ncpu_rw_o(bus4[28]),
    .cpu_a14_o(bus4[27]), .cpu_a13_o(bus4[26]), .cpu_d0_o(bus4[25]), .cpu_d7_o(bus4[24]),
    .busy_o(bus4[23]), .done_o(bus4[22]),
    .sh_control_o(bus4[20:16]), .sh_chr0_o(bus4[15:11]), .sh_chr1_o(bus4[10:6]),
    .sh_prg_o(bus4[5:1]), .sh_valid_o(bus4[0])
  );

  mmc1_config_sequencer #(.M2_HALF(1)) dut1 (
    .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid & use1), .req_ready_o(ready1),
    .req_sel_i(req_sel), .req_data_i(req_data), .req_reset_i(req_reset),
    .cpu_m2_o(bus1[30]), .ncpu_romsel_o(bus1[29]), .ncpu_rw_o(bus1[28]),
    .cpu_a14_o(bus1[27]), .cpu_a13_o(bus1[26]), .cpu_d0_o(bus1[25]), .cpu_d7_o(bus1[24]),
    .busy_o(bus1[23]), .done_o(bus1[22]),
    .sh_control_o(bus1[20:16]), .sh_chr0_o(bus1[15:11]), .sh_chr1_o(bus1[10:6]),
    .sh_prg_o(bus1[5:1]), .sh_valid_o(bus1[0])
  );

  assign bus4[21] = ready4;
  assign bus1[21] = ready1;

  wire [30:0] bus_s    = use1 ? bus1 : bus4;
  wire        m2       = bus_s[30];
  wire        romsel_n = bus_s[29];
  wire        rw_n     = bus_s[28];
  wire [1:0]  addr     = bus_s[27:26];
  wire        d0       = bus_s[25];
  wire        d7       = bus_s[24];
  wire        busy     = bus_s[23];
  wire        done     = bus_s[22];
  wire        ready    = bus_s[21];
  wire [20:0] shadows  = bus_s[20:0];

  localparam logic [30:0] RST_PACK = {1'b0, 1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1,
                                      5'b01100, 5'd0, 5'd0, 5'd0, 1'b0};

  typedef struct {
    logic [1:0]  sel;
    logic [4:0]  data;
    logic        rf;
    int          h;
    logic        b2b;
    logic [20:0] exp_sh;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [4:0] pick(input logic [1:0] s);
    case (s)
      2'b00:   return shadows[20:16];
      2'b01:   return shadows[15:11];
      2'b10:   return shadows[10:6];
      default: return shadows[5:1];
    endcase
  endfunction

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
    last_strobe = -1;
    prev_m2 = m2;
    prev_romsel = romsel_n;
  endtask

  // Called at a negedge in which the DUT is idle (or in its DONE cycle); returns at the DONE cycle.
  task automatic run_req(input logic [1:0] sel, input logic [4:0] data, input logic rf, input int h);
    int exp_done, c, done_c, nstrobe, idx, first_fall, last_fall;
    int bad_proto, bad_addr, bad_space;
    logic [4:0] bits, ctl_first, sh_last;
    logic d7_first, d7_other, v_first, cur_d0, cur_d7, done_ready, done_busy;
    exp_done = 1 + 20*h + (rf ? 4*h : 0);
    c = 0; done_c = -1; nstrobe = 0; first_fall = -1; last_fall = -1;
    bad_proto = 0; bad_addr = 0; bad_space = 0;
    bits = 5'd0; ctl_first = 5'd0; sh_last = 5'd0;
    d7_first = 1'b0; d7_other = 1'b0; v_first = 1'b0; cur_d0 = 1'b0; cur_d7 = 1'b0;
    done_ready = 1'b0; done_busy = 1'b1;
    check("ready_at_accept", ready, 1);
    req_sel = sel; req_data = data; req_reset = rf; req_valid = 1'b1;
    while (done_c < 0 && c < exp_done + 8*h + 8) begin
      @(negedge clk);
      c++;
      if (c == 1) begin
        req_valid = 1'b0; req_data = ~data; req_sel = ~sel; req_reset = ~rf;
      end
      if (m2 && !prev_m2) m2_rises++;
      if (!romsel_n) begin
        if (!m2 || rw_n) bad_proto++;
        if (addr != sel) bad_addr++;
        if (prev_romsel) begin
          if (last_strobe >= 0 && m2_rises - last_strobe != 2) bad_space++;
          last_strobe = m2_rises;
        end
        cur_d0 = d0; cur_d7 = d7;
      end else if (!prev_romsel) begin
        if (m2) bad_proto++;
        if (nstrobe == 0) begin
          first_fall = c; d7_first = cur_d7; v_first = shadows[0]; ctl_first = shadows[20:16];
        end else if (cur_d7) begin
          d7_other = 1'b1;
        end
        idx = nstrobe - (rf ? 1 : 0);
        if (idx >= 0 && idx < 5) bits[idx] = cur_d0;
        nstrobe++;
        last_fall = c;
        sh_last = pick(sel);
      end
      if (rw_n && (d0 || d7)) bad_proto++;
      if (done) begin
        done_c = c; done_ready = ready; done_busy = busy;
      end else if (!busy || ready) begin
        bad_proto++;
      end
      prev_m2 = m2;
      prev_romsel = romsel_n;
    end
    check("done_cycle", done_c, exp_done);
    check("strobe_count", nstrobe, 5 + (rf ? 1 : 0));
    check("serial_bits", bits, data);
    check("first_fall", first_fall, 1 + 2*h);
    check("last_fall", last_fall, 1 + 18*h + (rf ? 4*h : 0));
    check("d7_first", d7_first, rf);
    check("d7_other", d7_other, 0);
    check("addr_on_strobe", bad_addr, 0);
    check("bus_protocol", bad_proto, 0);
    check("strobe_spacing", bad_space, 0);
    check("shadow_at_last_fall", sh_last, data);
    check("done_ready_busy", {done_ready, done_busy}, 2'b10);
    if (rf) check("slot0_shadow", {v_first, ctl_first & 5'b01100}, {1'b1, 5'b01100});
  endtask

  task automatic apply_vec(input int i);
    use1 = (vecs[i].h == 1);
    if (!vecs[i].b2b) idle(3);
    run_req(vecs[i].sel, vecs[i].data, vecs[i].rf, vecs[i].h);
    check($sformatf("shadows_vec%0d", i), shadows, vecs[i].exp_sh);
  endtask

  initial begin
    vecs[0] = '{2'b11, 5'b10110, 1'b0, 4, 1'b0, {5'b01100, 5'b00000, 5'b00000, 5'b10110, 1'b0}};
    vecs[1] = '{2'b00, 5'b00011, 1'b1, 4, 1'b0, {5'b00011, 5'b00000, 5'b00000, 5'b10110, 1'b1}};
    vecs[2] = '{2'b01, 5'b11001, 1'b0, 4, 1'b0, {5'b00011, 5'b11001, 5'b00000, 5'b10110, 1'b1}};
    vecs[3] = '{2'b10, 5'b00101, 1'b1, 4, 1'b1, {5'b01111, 5'b11001, 5'b00101, 5'b10110, 1'b1}};
    vecs[4] = '{2'b00, 5'b10000, 1'b0, 4, 1'b1, {5'b10000, 5'b11001, 5'b00101, 5'b10110, 1'b1}};
    vecs[5] = '{2'b11, 5'b01011, 1'b1, 4, 1'b0, {5'b11100, 5'b11001, 5'b00101, 5'b01011, 1'b1}};
    vecs[6] = '{2'b11, 5'b00110, 1'b0, 1, 1'b0, {5'b01100, 5'b00000, 5'b00000, 5'b00110, 1'b0}};
    vecs[7] = '{2'b00, 5'b10101, 1'b1, 1, 1'b1, {5'b10101, 5'b00000, 5'b00000, 5'b00110, 1'b1}};

    // Reset held for two cycles.
    @(negedge clk);
    @(negedge clk);
    check("reset_state", bus_s, RST_PACK);
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_reset", {ready, shadows[0]}, 2'b10);

    for (int i = 0; i < 6; i++) apply_vec(i);

    // Abort during slot 3 of a RESET=0 request.
    use1 = 1'b0;
    idle(3);
    req_sel = 2'b01; req_data = 5'b10101; req_reset = 1'b0; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (34) @(negedge clk);
    check("busy_in_slot3", {busy, shadows[0]}, 2'b11);
    rst = 1'b1;
    @(negedge clk);
    check("abort_state", bus_s, RST_PACK);
    rst = 1'b0;
    idle(2);
    run_req(2'b00, 5'b00111, 1'b0, 4);
    check("shadows_after_abort", shadows, {5'b00111, 5'd0, 5'd0, 5'd0, 1'b0});

    for (int i = 6; i < 8; i++) apply_vec(i);

    idle(2);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mmc1_config_sequencer.md
# mmc1_config_sequencer

Bus-master sequencer that programs an MMC1-class mapper through its 5-bit serial register port. It accepts one parallel register write per request (register select plus 5-bit value) and emits the exact cartridge-bus write cycles needed: an optional shift-register reset write, then five LSB-first serial writes. It sits between the test or loader controller and the cartridge-side bus pins. It keeps shadow copies of the four mapper registers for the rest of the design.

## Interface
- M2_HALF, 4, CLK cycles per M2 half-period; legal range 1..255

- CLK  in  1  system clock; all outputs registered on rising edge
- RST  in  1  synchronous, active-high reset
- REQ_VALID  in  1  request present
- REQ_READY  out  1  sequencer can accept; transfer on REQ_VALID && REQ_READY
- REQ_SEL  in  2  target register: 00 control, 01 CHR bank 0, 10 CHR bank 1, 11 PRG bank
- REQ_DATA  in  5  value to load
- REQ_RESET  in  1  prepend a reset write (D7=1) before the serial load
- CPU_M2  out  1  generated M2; mapper samples on its falling edge
- nCPU_ROMSEL  out  1  low only while M2 high during a write
- nCPU_RW  out  1  low during setup and strobe of a write
- CPU_A14, CPU_A13  out  1 each  equal REQ_SEL[1:0] for the whole request
- CPU_D0  out  1  serial data bit
- CPU_D7  out  1  1 only during the reset write
- BUSY  out  1  request in progress
- DONE  out  1  one-cycle pulse when a request completes
- SH_CONTROL, SH_CHR0, SH_CHR1, SH_PRG  out  5 each  shadow registers
- SH_VALID  out  1  shadows match the mapper; requires a completed reset write

## Operation
- States: IDLE, SETUP, STROBE, GAP.
- One slot is SETUP (M2_HALF cycles) + STROBE (M2_HALF) + GAP (2*M2_HALF) = 4*M2_HALF cycles.
- IDLE:
  - REQ_READY=1.
  - On accept, latch SEL, DATA, RESET flag.
  - Set slot index to 0 if RESET, else 1. Go to SETUP.
- SETUP: M2=0, nROMSEL=1, nRW=0, A14/A13=SEL.
  - Slot 0: D7=1, D0=0.
  - Slot n≥1: D7=0, D0=DATA[n-1].
- STROBE: M2=1, nROMSEL=0. Other outputs are held from SETUP.
- GAP: the bus is idle for one full M2 period.
  - First M2_HALF cycles: M2=0. Second M2_HALF cycles: M2=1.
  - Throughout: nROMSEL=1, nRW=1, D0=0, D7=0.
  - The gap guarantees the mapper never sees writes in consecutive M2 cycles.
  - After GAP of slot 5, return to IDLE and pulse DONE. Otherwise increment the slot and go to SETUP.
- Shadow updates take effect in the cycle M2 falls (STROBE→GAP):
  - Slot 0: SH_CONTROL |= 5'b01100 (bitwise OR); SH_VALID=1.
  - Slot 5: the selected shadow is set to DATA.
- REQ_READY=0 from the cycle after accept until the DONE cycle. REQ_READY=1 in the DONE cycle.
- Back-to-back: a request accepted in the DONE cycle starts SETUP on the next cycle.

## Timing
- Reset values (cycle after RST sampled high):
  - M2=0, nROMSEL=1, nRW=1, A14=A13=0, D0=D7=0.
  - BUSY=0, DONE=0, REQ_READY=1.
  - SH_CONTROL=01100, SH_CHR0=SH_CHR1=SH_PRG=0, SH_VALID=0.
- RST mid-request aborts immediately. The bus returns to idle values the next cycle.
  - SH_VALID clears, because the mapper's shift register may be partially loaded.
  - A subsequent request with REQ_RESET=0 leaves SH_VALID=0 until a reset write completes.
- Latency with accept at cycle 0 and H=M2_HALF, no reset write:
  - Slot k (1..5) starts at cycle 1+4H(k-1).
  - Last M2 falling edge and shadow update: cycle 1+4H*4+2H.
  - DONE: cycle 1+20H.
- A reset write adds 4H cycles to all of the above.
- REQ_VALID and input changes while BUSY are ignored; the latched copy is used.
- M2 duty is 50% within write slots. M2 is never high with nROMSEL low outside STROBE.

## Test plan
- H=4, RST held 2 cycles -> all reset values above; REQ_READY=1 at cycle after release; SH_VALID=0.
- H=4, accept SEL=11 DATA=10110 RESET=0 -> D0 sequence 0,1,1,0,1 sampled at M2 falls at cycles 9,25,41,57,73; SH_PRG=10110 at cycle 73; DONE only at cycle 81; A14=A13=1 on every strobe.
- H=4, SEL=00 DATA=00011 RESET=1 -> first strobe has D7=1; SH_CONTROL=01100 and SH_VALID=1 at cycle 9; SH_CONTROL=00011 at cycle 89; DONE at cycle 97.
- REQ_VALID held high with two queued requests -> second accepted in the DONE cycle; next SETUP begins the following cycle; exactly one idle M2 period between any two strobes (bench checks nROMSEL never low in adjacent M2 periods).
- RST asserted during slot 3 -> next cycle bus idle, BUSY=0, SH_VALID=0, shadows unchanged except reset values; new RESET=0 request completes with SH_VALID still 0.
- H=1 -> slot length 4 cycles; DONE at cycle 21 after accept; all strobe and gap rules hold.
